bp_pht_ctrl: RTL and testbench

Controller for a single-ported pattern history table (PHT) of 2-bit saturating counters in the branch predictor. It sweeps the table to its initial value after reset. It arbitrates the one table port between F-stage prediction lookups and M-stage counter updates. Updates are buffered in a small queue and applied as read-modify-write, so the predictor datapath no longer needs a multi-ported, reset-all table.

---
 rtl/bp_pht_ctrl_if.sv | 31 +++
 rtl/bp_pht_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bp_pht_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pht_ctrl_if.sv
// Predictor-side bundle for the PHT controller: lookup request/result and M-stage update stream.
// The master is the predictor datapath; the slave is bp_pht_ctrl.
interface bp_pht_ctrl_if #(
  parameter int unsigned PhtDepth   = 7,
  parameter int unsigned QueueDepth = 4
) ();

  logic                          lookup_valid;
  logic [PhtDepth-1:0]           lookup_index;
  logic                          lookup_ready;
  logic                          pred_valid;
  logic                          pred_taken;
  logic [1:0]                    pred_ctr;
  logic                          upd_valid;
  logic [PhtDepth-1:0]           upd_index;
  logic                          upd_taken;
  logic                          upd_ready;
  logic [$clog2(QueueDepth):0]   q_count;
  logic                          init_done;

  modport master (
    output lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    input  lookup_ready, pred_valid, pred_taken, pred_ctr, upd_ready, q_count, init_done
  );

  modport slave (
    input  lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    output lookup_ready, pred_valid, pred_taken, pred_ctr, upd_ready, q_count, init_done
  );

endinterface

// File: rtl/bp_pht_ctrl.sv
// Single-ported PHT of 2-bit counters with post-reset init sweep, lookup/update arbitration
// and a FIFO of pending updates applied by serial read-modify-write.
module bp_pht_ctrl #(
  parameter int unsigned PhtDepth    = 7,
  parameter int unsigned QueueDepth  = 4,
  parameter logic [1:0]  InitVal     = 2'b01,
  parameter int unsigned StarveLimit = 8
) (
  input logic          clk,
  input logic          rst,
  bp_pht_ctrl_if.slave bus
);

  localparam int unsigned Entries = 1 << PhtDepth;
  localparam int unsigned QPtrW   = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW    = $clog2(QueueDepth) + 1;
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  typedef enum logic [1:0] {StInit, StIdle, StRd, StWr} state_e;

  state_e              state_q, state_d;
  logic [PhtDepth-1:0] ptr_q, ptr_d;
  logic                init_done_q, init_done_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [1:0]          ctr_q, ctr_d;
  logic                pred_valid_q, pred_valid_d;
  logic [1:0]          pred_ctr_q, pred_ctr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [QPtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [QPtrW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [PhtDepth-1:0] q_idx_q [QueueDepth];
  logic                q_tkn_q [QueueDepth];
  logic [1:0]          pht_q   [Entries];

  logic                force_upd, lookup_ready, lookup_acc, upd_ready, push, pop;
  logic [PhtDepth-1:0] head_idx, mem_addr;
  logic                head_tkn, mem_we;
  logic [1:0]          mem_rdata, mem_wdata;

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign force_upd    = (starve_q == StarveW'(StarveLimit));
  assign lookup_ready = init_done_q & ~force_upd;
  assign lookup_acc   = bus.lookup_valid & lookup_ready;
  assign upd_ready    = init_done_q & (count_q < CntW'(QueueDepth));
  assign push         = bus.upd_valid & upd_ready;
  assign head_idx     = q_idx_q[rd_ptr_q];
  assign head_tkn     = q_tkn_q[rd_ptr_q];

  // Single table port: sweep pointer, then an accepted lookup, else the queue head.
  always_comb begin
    mem_addr = head_idx;
    if (state_q == StInit) begin
      mem_addr = ptr_q;
    end else if (lookup_acc) begin
      mem_addr = bus.lookup_index;
    end
  end

  assign mem_rdata = pht_q[mem_addr];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    ctr_d       = ctr_q;
    mem_we      = 1'b0;
    mem_wdata   = InitVal;
    pop         = 1'b0;
    unique case (state_q)
      StInit: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PhtDepth'(1);
        if (ptr_q == '1) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (count_q != '0) begin
          state_d = StRd;
        end
      end
      StRd: begin
        if (lookup_acc) begin
          starve_d = starve_q + StarveW'(1);
        end else begin
          ctr_d    = mem_rdata;
          starve_d = '0;
          state_d  = StWr;
        end
      end
      StWr: begin
        if (lookup_acc) begin
          starve_d = starve_q + StarveW'(1);
        end else begin
          mem_we    = 1'b1;
          mem_wdata = ctr_sat(ctr_q, head_tkn);
          pop       = 1'b1;
          starve_d  = '0;
          // Non-empty after this pop if more entries remain or one arrives now.
          state_d   = ((count_q > CntW'(1)) || push) ? StRd : StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    count_d      = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d     = push ? wr_ptr_q + QPtrW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + QPtrW'(1) : rd_ptr_q;
    pred_valid_d = lookup_acc;
    pred_ctr_d   = lookup_acc ? mem_rdata : pred_ctr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      init_done_q  <= 1'b0;
      starve_q     <= '0;
      ctr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_ctr_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      init_done_q  <= init_done_d;
      starve_q     <= starve_d;
      ctr_q        <= ctr_d;
      pred_valid_q <= pred_valid_d;
      pred_ctr_q   <= pred_ctr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the table is swept and queue slots are written before use.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx_q[wr_ptr_q] <= bus.upd_index;
      q_tkn_q[wr_ptr_q] <= bus.upd_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pht_q[mem_addr] <= mem_wdata;
    end
  end

  assign bus.lookup_ready = lookup_ready;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_ctr_q[1];
  assign bus.pred_ctr     = pred_ctr_q;
  assign bus.upd_ready    = upd_ready;
  assign bus.q_count      = count_q;
  assign bus.init_done    = init_done_q;

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Scoreboard bench for bp_pht_ctrl: stimulus pushes acceptable prediction values into a queue,
// a monitor pops them whenever pred_valid is seen. The table model applies updates in order.
module tb_bp_pht_ctrl;

  localparam int unsigned PhtDepth    = 7;
  localparam int unsigned QueueDepth  = 4;
  localparam int unsigned StarveLimit = 8;
  localparam logic [1:0]  InitVal     = 2'b01;
  localparam int          Entries     = 1 << PhtDepth;

  typedef struct {int idx; bit tk;} upd_t;
  typedef struct {int idx; logic [3:0] ok;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bp_pht_ctrl_if #(.PhtDepth(PhtDepth), .QueueDepth(QueueDepth)) bus ();

  bp_pht_ctrl #(
    .PhtDepth(PhtDepth), .QueueDepth(QueueDepth), .InitVal(InitVal), .StarveLimit(StarveLimit)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  upd_t pend_q[$];
  exp_t sb_q[$];
  int   model [Entries];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lost = 0;
  int   qc_viol = 0;
  bit   stale_exact = 1'b0;
  bit   lr, ur;

  function automatic int sat(int v, bit t);
    if (t) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  // Any value between "no pending update applied" and "all pending updates applied" is legal.
  function automatic logic [3:0] accept_mask(int idx);
    int v = model[idx];
    logic [3:0] m = 4'b0000;
    m[v] = 1'b1;
    if (!stale_exact) begin
      foreach (pend_q[i]) begin
        if (pend_q[i].idx == idx) begin
          v = sat(v, pend_q[i].tk);
          m[v] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit lv, input int li, input bit uv, input int ui, input bit ut);
    @(negedge clk);
    bus.lookup_valid = lv;
    bus.lookup_index = li[PhtDepth-1:0];
    bus.upd_valid    = uv;
    bus.upd_index    = ui[PhtDepth-1:0];
    bus.upd_taken    = ut;
    lr = bus.lookup_ready;
    ur = bus.upd_ready;
    if (lv && lr) sb_q.push_back('{idx: li, ok: accept_mask(li)});
    if (uv && ur) pend_q.push_back('{idx: ui, tk: ut});
    else if (uv) lost++;
  endtask

  task automatic retire();
    foreach (pend_q[i]) model[pend_q[i].idx] = sat(model[pend_q[i].idx], pend_q[i].tk);
    pend_q.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0, 1'b0);
    retire();
  endtask

  task automatic lookup(input int idx);
    step(1'b1, idx, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_init(input string name);
    int cyc = 0;
    int bad = 0;
    while (bus.init_done !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.lookup_valid = (cyc < 100);
      bus.upd_valid    = (cyc < 100);
      bus.lookup_index = PhtDepth'($urandom);
      bus.upd_index    = PhtDepth'($urandom);
      if (bus.init_done !== 1'b1 && (bus.lookup_ready !== 1'b0 || bus.upd_ready !== 1'b0)) bad++;
    end
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    check({name, "_cycles"}, cyc, Entries);
    check({name, "_ready_low"}, bad, 0);
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (bus.q_count > QueueDepth) qc_viol++;
      if (bus.pred_valid === 1'b1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL pred_unexpected: pred_valid high with no accepted lookup, ctr=%0d",
                   bus.pred_ctr);
        end else begin
          e = sb_q.pop_front();
          if (e.ok[bus.pred_ctr] !== 1'b1 || bus.pred_taken !== bus.pred_ctr[1]) begin
            n_bad++;
            $display("FAIL lookup_idx%0d: got ctr=%0d taken=%0d, allowed ctr mask %b",
                     e.idx, bus.pred_ctr, bus.pred_taken, e.ok);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int first, gap, nf;
    bit urdy [5];
    bus.lookup_valid = 1'b0;
    bus.lookup_index = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_index    = '0;
    bus.upd_taken    = 1'b0;
    for (int i = 0; i < Entries; i++) model[i] = int'(InitVal);

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("rst_pred_valid", int'(bus.pred_valid), 0);
    check("rst_pred_taken", int'(bus.pred_taken), 0);
    check("rst_pred_ctr", int'(bus.pred_ctr), 0);
    check("rst_init_done", int'(bus.init_done), 0);
    check("rst_lookup_ready", int'(bus.lookup_ready), 0);
    check("rst_upd_ready", int'(bus.upd_ready), 0);
    check("rst_q_count", int'(bus.q_count), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_init("init");
    lost = 0;

    // Swept values
    lookup(0);
    lookup(64);
    lookup(127);

    // Saturation up then down on one index
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 0, 1'b1, 5, k < 4);
      drain(12);
      lookup(5);
    end

    // Starvation: lookups every cycle, one pending update
    first = -1; gap = 0; nf = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 20, i == 0, 30, 1'b1);
      if (!lr) begin
        nf++;
        if (first < 0) first = i;
        else if (nf == 2) gap = i - first;
      end
    end
    // Push cycle, one IDLE cycle, then StarveLimit stalled RD cycles before the forced one.
    check("starve_first_forced", first, StarveLimit + 2);
    check("starve_gap", gap, StarveLimit + 1);
    check("starve_forced_count", nf, 2);
    drain(12);
    lookup(30);

    // Back-pressure: five updates while lookups hold the port
    lost = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 20, 1'b1, 40 + i, 1'b1);
      urdy[i] = ur;
    end
    for (int i = 0; i < 5; i++) check($sformatf("bp_upd_ready%0d", i), int'(urdy[i]), i < 4);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    check("bp_q_count_full", int'(bus.q_count), QueueDepth);
    check("bp_lost", lost, 1);
    drain(20);
    for (int i = 40; i < 45; i++) lookup(i);

    // Stale read of an index with a queued update
    step(1'b0, 0, 1'b1, 9, 1'b1);
    stale_exact = 1'b1;
    step(1'b1, 9, 1'b0, 0, 1'b0);
    stale_exact = 1'b0;
    drain(12);
    lookup(9);

    // Randomized traffic, drained periodically so the model can retire updates
    lost = 0;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 15),
             $urandom_range(0, 9) < 3, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end
      drain(16);
    end
    for (int i = 0; i < 16; i++) lookup(i);
    $display("note: %0d updates were dropped while upd_ready was low", lost);

    // Reset mid-RD with three queued updates
    for (int i = 0; i < 3; i++) step(1'b1, 20, 1'b1, 50 + i, 1'b0);
    @(negedge clk);
    check("mid_q_count", int'(bus.q_count), 3);
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_q_count", int'(bus.q_count), 0);
    check("mid_rst_init_done", int'(bus.init_done), 0);
    check("mid_rst_lookup_ready", int'(bus.lookup_ready), 0);
    check("mid_rst_upd_ready", int'(bus.upd_ready), 0);
    pend_q.delete();
    for (int i = 0; i < Entries; i++) model[i] = int'(InitVal);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_init("reinit");
    for (int i = 50; i < 53; i++) lookup(i);
    lookup(5);

    repeat (4) step(1'b0, 0, 1'b0, 0, 1'b0);
    check("sb_empty", sb_q.size(), 0);
    check("q_count_bound", qc_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
